// File: rtl/interp_scaler_p.sv
// Parametrised bilinear/nearest window scaler reading a synchronous ROM.
// Define INTERP_ROUND_EN to round bilinear results half up instead of truncating.
module interp_scaler_p #(
  parameter int DW       = 8,
  parameter int IMG_LOG2 = 6,
  parameter int SZ_W     = 4,
  parameter int FRAC     = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [IMG_LOG2-1:0]   H0,
  input  logic [IMG_LOG2-1:0]   V0,
  input  logic [SZ_W-1:0]       SW,
  input  logic [SZ_W-1:0]       SH,
  output logic                  REN,
  output logic [2*IMG_LOG2-1:0] ADDR,
  input  logic [DW-1:0]         R_DATA,
  output logic [DW-1:0]         O_DATA,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int OUT_N = (1 << FRAC) + 1;
  localparam int CW    = FRAC + 1;
  localparam int PW    = FRAC + 1 + SZ_W;
  localparam int IW    = SZ_W + 1;
  localparam int WW    = FRAC + 1;
  localparam int AW    = 2*DW + 2*FRAC + 2;
  localparam logic [CW-1:0] LAST = CW'(OUT_N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CAPTURE, S_CALC, S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [IMG_LOG2-1:0]   h0_q, h0_d, v0_q, v0_d;
  logic [SZ_W-1:0]       sw1_q, sw1_d, sh1_q, sh1_d;
  logic                  mode_q, mode_d;
  logic [CW-1:0]         i_q, i_d, j_q, j_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic [DW-1:0]         ul_q, ul_d, ur_q, ur_d, ll_q, ll_d, lr_q, lr_d;
  logic                  ren_q, ren_d;
  logic [2*IMG_LOG2-1:0] addr_q, addr_d;
  logic [DW-1:0]         odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [PW-1:0]         px, py;
  logic [IW-1:0]         ix, iy;
  logic [FRAC-1:0]       fx, fy;
  logic [WW-1:0]         wx0, wx1, wy0, wy1;
  logic                  need_ur, need_ll, need_lr;
  logic                  dx, dy;
  logic [IMG_LOG2-1:0]   col, row;
  logic [AW-1:0]         top, bot, acc, res;
  logic [DW-1:0]         calc_pix;

  assign px  = PW'(i_q) * PW'(sw1_q);
  assign py  = PW'(j_q) * PW'(sh1_q);
  assign ix  = px[PW-1:FRAC];
  assign iy  = py[PW-1:FRAC];
  assign fx  = px[FRAC-1:0];
  assign fy  = py[FRAC-1:0];
  assign wx1 = WW'(fx);
  assign wy1 = WW'(fy);
  assign wx0 = WW'(1 << FRAC) - wx1;
  assign wy0 = WW'(1 << FRAC) - wy1;

  assign need_ur = |fx;
  assign need_ll = |fy;
  assign need_lr = need_ur & need_ll;

  // Nearest rounds each axis by the top fraction bit; bilinear walks UL,UR,LL,LR via sel.
  assign dx  = mode_q ? fx[FRAC-1] : sel_q[0];
  assign dy  = mode_q ? fy[FRAC-1] : sel_q[1];
  assign col = h0_q + IMG_LOG2'(ix) + IMG_LOG2'(dx);
  assign row = v0_q + IMG_LOG2'(iy) + IMG_LOG2'(dy);

  assign top = AW'(ul_q) * AW'(wx0) + AW'(ur_q) * AW'(wx1);
  assign bot = AW'(ll_q) * AW'(wx0) + AW'(lr_q) * AW'(wx1);
  assign acc = top * AW'(wy0) + bot * AW'(wy1);
`ifdef INTERP_ROUND_EN
  assign res = acc + (AW'(1) << (2*FRAC - 1));
`else
  assign res = acc;
`endif
  assign calc_pix = DW'(res >> (2*FRAC));

  always_comb begin
    state_d  = state_q;
    h0_d     = h0_q;
    v0_d     = v0_q;
    sw1_d    = sw1_q;
    sh1_d    = sh1_q;
    mode_d   = mode_q;
    i_d      = i_q;
    j_d      = j_q;
    sel_d    = sel_q;
    wcnt_d   = wcnt_q;
    ul_d     = ul_q;
    ur_d     = ur_q;
    ll_d     = ll_q;
    lr_d     = lr_q;
    ren_d    = 1'b1;
    addr_d   = addr_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          h0_d    = H0;
          v0_d    = V0;
          sw1_d   = (SW == '0) ? '0 : SW - SZ_W'(1);
          sh1_d   = (SH == '0) ? '0 : SH - SZ_W'(1);
          mode_d  = MODE;
          i_d     = '0;
          j_d     = '0;
          sel_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        addr_d  = {row, col};
        ren_d   = 1'b0;
        wcnt_d  = '0;
        state_d = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (wcnt_q == 2'(RD_LAT - 2)) state_d = S_CAPTURE;
        else                          wcnt_d  = wcnt_q + 2'd1;
      end
      S_CAPTURE: begin
        if (mode_q) begin
          odata_d  = R_DATA;
          ovalid_d = 1'b1;
          state_d  = S_OUT;
        end else begin
          case (sel_q)
            2'd0:    ul_d = R_DATA;
            2'd1:    ur_d = R_DATA;
            2'd2:    ll_d = R_DATA;
            default: lr_d = R_DATA;
          endcase
          // Skipped corners keep stale data but carry a zero weight.
          state_d = S_CALC;
          case (sel_q)
            2'd0: begin
              if (need_ur)      begin sel_d = 2'd1; state_d = S_FETCH; end
              else if (need_ll) begin sel_d = 2'd2; state_d = S_FETCH; end
            end
            2'd1: if (need_ll) begin sel_d = 2'd2; state_d = S_FETCH; end
            2'd2: if (need_lr) begin sel_d = 2'd3; state_d = S_FETCH; end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        odata_d  = calc_pix;
        ovalid_d = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (O_READY) begin
          ovalid_d = 1'b0;
          sel_d    = '0;
          if (i_q == LAST && j_q == LAST) begin
            i_d     = '0;
            j_d     = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            if (i_q == LAST) begin
              i_d = '0;
              j_d = j_q + CW'(1);
            end else begin
              i_d = i_q + CW'(1);
            end
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      h0_q     <= '0;
      v0_q     <= '0;
      sw1_q    <= '0;
      sh1_q    <= '0;
      mode_q   <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      sel_q    <= '0;
      wcnt_q   <= '0;
      ul_q     <= '0;
      ur_q     <= '0;
      ll_q     <= '0;
      lr_q     <= '0;
      ren_q    <= 1'b1;
      addr_q   <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      h0_q     <= h0_d;
      v0_q     <= v0_d;
      sw1_q    <= sw1_d;
      sh1_q    <= sh1_d;
      mode_q   <= mode_d;
      i_q      <= i_d;
      j_q      <= j_d;
      sel_q    <= sel_d;
      wcnt_q   <= wcnt_d;
      ul_q     <= ul_d;
      ur_q     <= ur_d;
      ll_q     <= ll_d;
      lr_q     <= lr_d;
      ren_q    <= ren_d;
      addr_q   <= addr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign REN     = ren_q;
  assign ADDR    = addr_q;
  assign O_DATA  = odata_q;
  assign O_VALID = ovalid_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
